// File: rtl/lane_queue_array.sv
// lane_queue_array
// Array of independent per-lane car queues. Each lane counts cars that
// arrive (rising edge of arrive_in) and cars that cross (rising edge of
// cross_in while the lane light permits it). Arrivals into a full lane
// are dropped and flagged in a sticky overflow bit. Aggregate views
// (empty, full, total, busiest lane) are derived from the registered
// counts.
module lane_queue_array #(
  parameter int NUM_LANES   = 4,
  parameter int MAX_CARS    = 10,
  parameter int YELLOW_PASS = 0,
  localparam int CNT_W = $clog2(MAX_CARS + 1),
  localparam int TOT_W = $clog2(NUM_LANES * MAX_CARS + 1),
  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LANES-1:0]       arrive_in,
  input  logic [NUM_LANES-1:0]       cross_in,
  input  logic [2*NUM_LANES-1:0]     light,
  input  logic [NUM_LANES-1:0]       ovf_clr,
  output logic [CNT_W*NUM_LANES-1:0] count,
  output logic [NUM_LANES-1:0]       empty,
  output logic [NUM_LANES-1:0]       full,
  output logic [NUM_LANES-1:0]       ovf,
  output logic [TOT_W-1:0]           total,
  output logic [IDX_W-1:0]           busiest
);

  // Light encodings; 2'b11 is deliberately absent so it behaves as RED.
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CARS);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Edge-detect history and per-lane state.
  logic [NUM_LANES-1:0] arrive_prev_q;
  logic [NUM_LANES-1:0] cross_prev_q;
  logic [CNT_W-1:0]     count_q [NUM_LANES];
  logic [CNT_W-1:0]     count_d [NUM_LANES];
  logic [NUM_LANES-1:0] ovf_q;
  logic [NUM_LANES-1:0] ovf_d;

  // Per-lane event decode.
  logic [NUM_LANES-1:0] arrive_rise_s;
  logic [NUM_LANES-1:0] cross_rise_s;
  logic [NUM_LANES-1:0] pass_s;
  logic [NUM_LANES-1:0] depart_s;
  logic [NUM_LANES-1:0] accept_s;
  logic [NUM_LANES-1:0] drop_s;

  // Aggregate helpers.
  logic [CNT_W-1:0]     max_cnt_s;

  // Rising-edge detection against the previous-cycle input levels.
  always_comb begin
    arrive_rise_s = arrive_in & ~arrive_prev_q;
    cross_rise_s  = cross_in  & ~cross_prev_q;
  end

  // Per-lane arrival/departure decision and next count / overflow state.
  always_comb begin
    pass_s   = {NUM_LANES{1'b0}};
    depart_s = {NUM_LANES{1'b0}};
    accept_s = {NUM_LANES{1'b0}};
    drop_s   = {NUM_LANES{1'b0}};
    count_d  = count_q;
    ovf_d    = ovf_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      pass_s[i] = (light[2*i +: 2] == LIGHT_GREEN) ||
                  ((YELLOW_PASS != 0) && (light[2*i +: 2] == LIGHT_YELLOW));
      // A crossing only counts when a car is actually waiting.
      depart_s[i] = cross_rise_s[i] && (count_q[i] != CNT_ZERO) && pass_s[i];
      // A full lane can still take a car if one leaves on the same edge.
      accept_s[i] = arrive_rise_s[i] && ((count_q[i] < CNT_MAX) || depart_s[i]);
      drop_s[i]   = arrive_rise_s[i] && !accept_s[i];

      case ({accept_s[i], depart_s[i]})
        2'b10:   count_d[i] = count_q[i] + CNT_ONE;
        2'b01:   count_d[i] = count_q[i] - CNT_ONE;
        default: count_d[i] = count_q[i];
      endcase

      // Setting the sticky flag takes priority over clearing it.
      if (drop_s[i]) begin
        ovf_d[i] = 1'b1;
      end else if (ovf_clr[i]) begin
        ovf_d[i] = 1'b0;
      end else begin
        ovf_d[i] = ovf_q[i];
      end
    end
  end

  // State registers; reset primes the edge history with the live inputs so
  // levels held across reset release do not look like new events.
  always_ff @(posedge clk) begin
    arrive_prev_q <= arrive_in;
    cross_prev_q  <= cross_in;
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        count_q[i] <= CNT_ZERO;
      end
      ovf_q <= {NUM_LANES{1'b0}};
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Flatten counts and derive per-lane status flags.
  always_comb begin
    count = {(CNT_W*NUM_LANES){1'b0}};
    empty = {NUM_LANES{1'b0}};
    full  = {NUM_LANES{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      count[CNT_W*i +: CNT_W] = count_q[i];
      empty[i] = (count_q[i] == CNT_ZERO);
      full[i]  = (count_q[i] == CNT_MAX);
    end
  end

  // Sum of all lanes and lowest-index lane holding the largest count.
  always_comb begin
    total     = {TOT_W{1'b0}};
    busiest   = {IDX_W{1'b0}};
    max_cnt_s = count_q[0];
    for (int i = 0; i < NUM_LANES; i++) begin
      total = total + TOT_W'(count_q[i]);
      // Strict compare keeps the lowest index on ties.
      if (count_q[i] > max_cnt_s) begin
        max_cnt_s = count_q[i];
        busiest   = IDX_W'(i);
      end else begin
        max_cnt_s = max_cnt_s;
      end
    end
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_lane_queue_array.sv
// Bench for lane_queue_array: two instances (YELLOW_PASS 0 and 1) share
// stimulus; a queue-level reference model tracks both every cycle, plus a
// table of directed vectors and hand-written corner sequences.
module tb_lane_queue_array;

  localparam int NL  = 4;
  localparam int MAX = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arrive_in, cross_in, ovf_clr;
  logic [7:0]  light;

  logic [15:0] count0, count1;
  logic [3:0]  empty0, empty1, full0, full1, ovf0, ovf1;
  logic [5:0]  total0, total1;
  logic [1:0]  busiest0, busiest1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: car counts per lane per instance.
  int m_cnt [2][NL];
  bit m_ovf [2][NL];
  bit m_pa  [NL];
  bit m_pc  [NL];

  lane_queue_array #(.NUM_LANES(4), .MAX_CARS(10), .YELLOW_PASS(0)) u_dut0 (
    .clk(clk), .rst(rst), .arrive_in(arrive_in), .cross_in(cross_in),
    .light(light), .ovf_clr(ovf_clr), .count(count0), .empty(empty0),
    .full(full0), .ovf(ovf0), .total(total0), .busiest(busiest0));

  lane_queue_array #(.NUM_LANES(4), .MAX_CARS(10), .YELLOW_PASS(1)) u_dut1 (
    .clk(clk), .rst(rst), .arrive_in(arrive_in), .cross_in(cross_in),
    .light(light), .ovf_clr(ovf_clr), .count(count1), .empty(empty1),
    .full(full1), .ovf(ovf1), .total(total1), .busiest(busiest1));

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the queue rules.
  task automatic model_step();
    for (int i = 0; i < NL; i++) begin
      bit ar, cr;
      int lt;
      ar = arrive_in[i] && !m_pa[i];
      cr = cross_in[i]  && !m_pc[i];
      lt = int'(light[2*i +: 2]);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_cnt[k][i] = 0;
          m_ovf[k][i] = 0;
        end else begin
          bit green_ok, dep, arrived;
          green_ok = (lt == 2) || (k == 1 && lt == 1);
          dep      = cr && green_ok && (m_cnt[k][i] > 0);
          arrived  = ar && (m_cnt[k][i] < MAX || dep);
          m_cnt[k][i] = m_cnt[k][i] + (arrived ? 1 : 0) - (dep ? 1 : 0);
          if (ar && !arrived) m_ovf[k][i] = 1;
          else if (ovf_clr[i]) m_ovf[k][i] = 0;
        end
      end
      m_pa[i] = arrive_in[i];
      m_pc[i] = cross_in[i];
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      logic [15:0] ec;
      logic [3:0]  ee, ef, eo;
      int          tot, best;
      ec = '0; ee = '0; ef = '0; eo = '0; tot = 0; best = 0;
      for (int i = 0; i < NL; i++) begin
        ec[4*i +: 4] = 4'(m_cnt[k][i]);
        ee[i] = (m_cnt[k][i] == 0);
        ef[i] = (m_cnt[k][i] == MAX);
        eo[i] = m_ovf[k][i];
        tot  += m_cnt[k][i];
        if (m_cnt[k][i] > m_cnt[k][best]) best = i;
      end
      compare($sformatf("model%0d.count", k),   32'(k == 0 ? count0 : count1), 32'(ec));
      compare($sformatf("model%0d.empty", k),   32'(k == 0 ? empty0 : empty1), 32'(ee));
      compare($sformatf("model%0d.full", k),    32'(k == 0 ? full0 : full1),   32'(ef));
      compare($sformatf("model%0d.ovf", k),     32'(k == 0 ? ovf0 : ovf1),     32'(eo));
      compare($sformatf("model%0d.total", k),   32'(k == 0 ? total0 : total1), 32'(tot));
      compare($sformatf("model%0d.busiest", k), 32'(k == 0 ? busiest0 : busiest1), 32'(best));
    end
  endtask

  // One clock edge: update model at the edge, sample DUT 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    arrive_in = 4'b0000; cross_in = 4'b0000; ovf_clr = 4'b0000; light = 8'h00;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic pulse_arrive(input logic [3:0] mask);
    arrive_in = mask; cycle();
    arrive_in = 4'b0000; cycle();
  endtask

  task automatic pulse_cross(input logic [3:0] mask);
    cross_in = mask; cycle();
    cross_in = 4'b0000; cycle();
  endtask

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  c;
    logic [7:0]  lt;
    logic [3:0]  clr;
    logic [15:0] exp_cnt;
    logic [3:0]  exp_ovf;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // Lane 0: three arrivals, crossings on RED / GREEN / 11 / YELLOW.
    tbl[0]  = '{4'b0001, 4'b0000, 8'h00, 4'b0000, 16'h0001, 4'b0000};
    tbl[1]  = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 16'h0001, 4'b0000};
    tbl[2]  = '{4'b0001, 4'b0000, 8'h00, 4'b0000, 16'h0002, 4'b0000};
    tbl[3]  = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 16'h0002, 4'b0000};
    tbl[4]  = '{4'b0001, 4'b0000, 8'h00, 4'b0000, 16'h0003, 4'b0000};
    tbl[5]  = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 16'h0003, 4'b0000};
    tbl[6]  = '{4'b0000, 4'b0001, 8'h00, 4'b0000, 16'h0003, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 16'h0003, 4'b0000};
    tbl[8]  = '{4'b0000, 4'b0001, 8'h00, 4'b0000, 16'h0003, 4'b0000};
    tbl[9]  = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 16'h0003, 4'b0000};
    tbl[10] = '{4'b0000, 4'b0001, 8'h02, 4'b0000, 16'h0002, 4'b0000};
    tbl[11] = '{4'b0000, 4'b0000, 8'h02, 4'b0000, 16'h0002, 4'b0000};
    tbl[12] = '{4'b0000, 4'b0001, 8'h02, 4'b0000, 16'h0001, 4'b0000};
    tbl[13] = '{4'b0000, 4'b0000, 8'h02, 4'b0000, 16'h0001, 4'b0000};
    tbl[14] = '{4'b0000, 4'b0001, 8'h03, 4'b0000, 16'h0001, 4'b0000};
    tbl[15] = '{4'b0000, 4'b0000, 8'h03, 4'b0000, 16'h0001, 4'b0000};
    tbl[16] = '{4'b0000, 4'b0001, 8'h01, 4'b0000, 16'h0001, 4'b0000};
    tbl[17] = '{4'b0000, 4'b0000, 8'h01, 4'b0000, 16'h0001, 4'b0000};

    do_reset();
    compare("reset.count", 32'(count0), 32'h0);
    compare("reset.empty", 32'(empty0), 32'hF);
    compare("reset.total", 32'(total0), 32'h0);

    for (int v = 0; v < 18; v++) begin
      arrive_in = tbl[v].a; cross_in = tbl[v].c; light = tbl[v].lt; ovf_clr = tbl[v].clr;
      cycle();
      compare($sformatf("tbl[%0d].count", v), 32'(count0), 32'(tbl[v].exp_cnt));
      compare($sformatf("tbl[%0d].ovf", v),   32'(ovf0),   32'(tbl[v].exp_ovf));
    end

    // Lane 1 overflow, set-wins-over-clear, then clear.
    do_reset();
    for (int n = 0; n < 11; n++) pulse_arrive(4'b0010);
    compare("ovf.count1", 32'(count0[7:4]), 32'd10);
    compare("ovf.full1",  32'(full0[1]),    32'd1);
    compare("ovf.flag1",  32'(ovf0[1]),     32'd1);
    arrive_in = 4'b0010; ovf_clr = 4'b0010; cycle();
    compare("ovf.setwins", 32'(ovf0[1]), 32'd1);
    arrive_in = 4'b0000; ovf_clr = 4'b0000; cycle();
    ovf_clr = 4'b0010; cycle();
    ovf_clr = 4'b0000;
    compare("ovf.cleared", 32'(ovf0[1]),     32'd0);
    compare("ovf.cntkeep", 32'(count0[7:4]), 32'd10);

    // Lane 2: simultaneous arrive+cross when full and when empty.
    do_reset();
    for (int n = 0; n < 10; n++) pulse_arrive(4'b0100);
    light = 8'h20;
    arrive_in = 4'b0100; cross_in = 4'b0100; cycle();
    compare("both.full.count", 32'(count0[11:8]), 32'd10);
    compare("both.full.ovf",   32'(ovf0[2]),      32'd0);
    arrive_in = 4'b0000; cross_in = 4'b0000; cycle();
    for (int n = 0; n < 10; n++) pulse_cross(4'b0100);
    compare("drain.count", 32'(count0[11:8]), 32'd0);
    pulse_cross(4'b0100);
    compare("drain.nowrap", 32'(count0[11:8]), 32'd0);
    arrive_in = 4'b0100; cross_in = 4'b0100; cycle();
    compare("both.empty.count", 32'(count0[11:8]), 32'd1);
    arrive_in = 4'b0000; cross_in = 4'b0000; cycle();

    // Lane 3 on YELLOW: only the YELLOW_PASS=1 instance lets a car through.
    do_reset();
    pulse_arrive(4'b1000);
    pulse_arrive(4'b1000);
    light = 8'h40;
    pulse_cross(4'b1000);
    compare("yellow.pass0", 32'(count0[15:12]), 32'd2);
    compare("yellow.pass1", 32'(count1[15:12]), 32'd1);

    // Level held high through reset release produces no arrival.
    do_reset();
    arrive_in = 4'b0001; rst = 1'b1; cycle(); cycle();
    rst = 1'b0; cycle(); cycle(); cycle();
    compare("hold.norise", 32'(count0[3:0]), 32'd0);
    arrive_in = 4'b0000; cycle();
    arrive_in = 4'b0001; cycle();
    compare("hold.rise", 32'(count0[3:0]), 32'd1);
    // A rise in the same cycle as reset is discarded.
    arrive_in = 4'b0000; cycle();
    arrive_in = 4'b0001; rst = 1'b1; cycle();
    compare("rst.rise", 32'(count0[3:0]), 32'd0);
    rst = 1'b0; cycle();
    compare("rst.after", 32'(count0[3:0]), 32'd0);
    arrive_in = 4'b0000; cycle();

    // Aggregates: counts {3,5,5,1}.
    do_reset();
    pulse_arrive(4'b1111);
    pulse_arrive(4'b0111);
    pulse_arrive(4'b0111);
    pulse_arrive(4'b0110);
    pulse_arrive(4'b0110);
    compare("agg.total",   32'(total0),   32'd14);
    compare("agg.busiest", 32'(busiest0), 32'd1);
    do_reset();
    compare("agg0.total",   32'(total0),   32'd0);
    compare("agg0.busiest", 32'(busiest0), 32'd0);
    compare("agg0.empty",   32'(empty0),   32'hF);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 4000; n++) begin
      arrive_in = 4'($urandom);
      cross_in  = 4'($urandom);
      light     = 8'($urandom);
      ovf_clr   = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
      rst       = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_queue_array.md
LANE_QUEUE_ARRAY -- requirements
Module: lane_queue_array

Interface
REQ-001 Parameter NUM_LANES, default 4, number of independent lanes (1..16).
REQ-002 Parameter MAX_CARS, default 10, per-lane queue capacity (1..255).
REQ-003 Parameter YELLOW_PASS, default 0, 1 = crossing also permitted on YELLOW.
REQ-004 Derived CNT_W = $clog2(MAX_CARS+1); TOT_W = $clog2(NUM_LANES*MAX_CARS+1); IDX_W = max(1,$clog2(NUM_LANES)).
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 arrive_in  input  NUM_LANES  per-lane car-arrival level signal, bit i = lane i.
REQ-008 cross_in  input  NUM_LANES  per-lane car-cross request level signal.
REQ-009 light  input  2*NUM_LANES  per-lane light, lane i at [2i+1:2i]; 00 RED, 01 YELLOW, 10 GREEN, 11 treated as RED.
REQ-010 ovf_clr  input  NUM_LANES  per-lane clear of sticky overflow flag.
REQ-011 count  output  CNT_W*NUM_LANES  per-lane queue count, lane i at [CNT_W*i +: CNT_W].
REQ-012 empty  output  NUM_LANES  lane count == 0.
REQ-013 full  output  NUM_LANES  lane count == MAX_CARS.
REQ-014 ovf  output  NUM_LANES  sticky: arrival was dropped because lane full.
REQ-015 total  output  TOT_W  sum of all lane counts.
REQ-016 busiest  output  IDX_W  index of lane with largest count.

Function
REQ-017 Each lane SHALL register arrive_in and cross_in every cycle (prev regs); rise = in & ~prev.
REQ-018 A rise SHALL affect count on the same clock edge at which prev captures the new high level (1-cycle latency from input going high to count output change).
REQ-019 A depart SHALL be valid when cross rise && count>0 && (light==GREEN || (YELLOW_PASS && light==YELLOW)).
REQ-020 An arrival SHALL be accepted when arrive rise && (count<MAX_CARS || depart valid same cycle).
REQ-021 Accepted arrival only: count+1; valid depart only: count-1; both: count unchanged.
REQ-022 Arrive rise with count==MAX_CARS and no valid depart: count unchanged, ovf[i] set to 1.
REQ-023 Cross rise with count==0, or light not permitting: ignored, no state change, no flag.
REQ-024 Count SHALL never exceed MAX_CARS nor wrap below 0.
REQ-025 ovf[i] SHALL clear on ovf_clr[i]; same-cycle set and clear: set wins.
REQ-026 empty, full, total, busiest SHALL be combinational from registered counts (same cycle as count).
REQ-027 busiest SHALL be the lowest index among lanes with maximal count; all-empty gives 0.
REQ-028 total SHALL be computed at TOT_W width without overflow.
REQ-029 Lanes SHALL be fully independent; no cross-lane interaction except total/busiest.

Reset
REQ-030 During rst: all counts 0, ovf 0, empty all 1, full 0, total 0, busiest 0.
REQ-031 During rst prev regs SHALL load current arrive_in/cross_in, so levels held high across reset release generate no rise.
REQ-032 rst asserted mid-operation SHALL discard any same-cycle rise events.

Verification
REQ-033 Lane 0 (default params), 3 arrival pulses, light RED, 2 cross pulses -> count[0]=3, crosses ignored; light GREEN, 2 cross pulses -> count[0]=1.
REQ-034 Lane 1, 11 arrival pulses -> count[1]=10, full[1]=1, ovf[1]=1; ovf_clr[1] pulse -> ovf[1]=0, count unchanged.
REQ-035 Lane 2 full (10), GREEN, arrive and cross rise same cycle -> count stays 10, ovf[2]=0; at count 0 same stimulus -> count=1.
REQ-036 YELLOW_PASS=0 vs 1, lane 3 count 2, light YELLOW, cross pulse -> count 2 vs 1 respectively.
REQ-037 arrive_in[0] held high through rst release -> count[0] stays 0 until input falls and rises again, then 1.
REQ-038 Counts {3,5,5,1} -> total=14, busiest=1; lane counts 0 -> total=0, busiest=0, empty=4'b1111.
